// File: rtl/slice_tx_gate_pkg.sv
// Shared xpu definitions for the slice-gated tx request path.
// States, queue geometry and the round-robin reset pointer.
package slice_tx_gate_pkg;

    localparam int NUM_TX_QUEUE = 3;
    localparam int QUEUE_IDX_WIDTH = 2;

    // Queue 0 gets first priority after reset.
    localparam logic [QUEUE_IDX_WIDTH-1:0] RR_RESET_IDX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } tx_state_e;

    function automatic logic [QUEUE_IDX_WIDTH-1:0] rr_next(
        input logic [QUEUE_IDX_WIDTH-1:0] idx
    );
        logic [QUEUE_IDX_WIDTH-1:0] nxt;
        nxt = 2'd0;
        unique case (1'b1)
            (idx == 2'd0): nxt = 2'd1;
            (idx == 2'd1): nxt = 2'd2;
            default:       nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/slice_rr_pick.sv
// Combinational round-robin picker over the three tx queues.
// Search starts one past the last granted queue, wrapping mod 3.
module slice_rr_pick
    import slice_tx_gate_pkg::*;
(
    input  logic [NUM_TX_QUEUE-1:0]    eligible,
    input  logic [QUEUE_IDX_WIDTH-1:0] last_granted,
    output logic                       valid,
    output logic [QUEUE_IDX_WIDTH-1:0] idx
);

    logic [QUEUE_IDX_WIDTH-1:0] c0;
    logic [QUEUE_IDX_WIDTH-1:0] c1;
    logic [QUEUE_IDX_WIDTH-1:0] c2;

    assign c0 = rr_next(last_granted);
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    always_comb begin
        valid = |eligible;
        idx   = '0;
        if (eligible[c0]) begin
            idx = c0;
        end else if (eligible[c1]) begin
            idx = c1;
        end else if (eligible[c2]) begin
            idx = c2;
        end
    end

endmodule

// File: rtl/slice_tx_gate.sv
// Gates tx requests by per-queue slice enables, arbitrates round-robin
// and tracks each granted frame through accept, completion and timeout.
module slice_tx_gate
    import slice_tx_gate_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slice_en0,
    input  logic                       slice_en1,
    input  logic                       slice_en2,
    input  logic [NUM_TX_QUEUE-1:0]    queue_pending,
    input  logic                       tx_ready,
    input  logic                       tx_ack,
    input  logic                       tx_done,
    input  logic [TIMEOUT_WIDTH-1:0]   tx_timeout_cycles,
    output logic                       tx_req,
    output logic [QUEUE_IDX_WIDTH-1:0] tx_queue_idx,
    output logic                       busy,
    output logic                       timeout_pulse,
    output logic [QUEUE_IDX_WIDTH-1:0] last_granted
);

    tx_state_e                  state;
    logic [NUM_TX_QUEUE-1:0]    eligible;
    logic                       pick_valid;
    logic [QUEUE_IDX_WIDTH-1:0] pick_idx;
    logic [TIMEOUT_WIDTH-1:0]   wd;
    logic [TIMEOUT_WIDTH-1:0]   wd_next;
    logic                       expire;

    assign eligible = queue_pending
                    & {slice_en2, slice_en1, slice_en0};

    // Compare against the post-increment count so expiry lands
    // exactly limit edges after the accept edge.
    assign wd_next = (&wd) ? wd : wd + 1'b1;
    assign expire  = (tx_timeout_cycles != '0)
                  && (wd_next == tx_timeout_cycles);

    slice_rr_pick u_pick (
        .eligible     (eligible),
        .last_granted (last_granted),
        .valid        (pick_valid),
        .idx          (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_req        <= 1'b0;
            tx_queue_idx  <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            last_granted  <= RR_RESET_IDX;
            wd            <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid && tx_ready) begin
                        tx_queue_idx <= pick_idx;
                        tx_req       <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_ack) begin
                        tx_req <= 1'b0;
                        wd     <= '0;
                        state  <= ST_ACTIVE;
                    end else if (!eligible[tx_queue_idx]) begin
                        tx_req <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    wd <= wd_next;
                    if (tx_done) begin
                        last_granted <= tx_queue_idx;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (expire) begin
                        timeout_pulse <= 1'b1;
                        last_granted  <= tx_queue_idx;
                        busy          <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    tx_req <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
